soc_uart_rx: RTL and testbench

Serial UART receiver with a receive FIFO, exposed as a bus responder on the SoC peripheral bus (ce/we/oe/rdy/offset handshake used by the CPU). It deserialises 8N1 frames from the `rxd` pin, buffers bytes, and raises a level interrupt toward the CPU when data or an error is pending. It sits beside the transmit UART in the 0xF800xxxx I/O window.

---
 rtl/soc_uart_pkg.sv | 31 +++
 rtl/soc_fifo.sv | 66 ++++++
 rtl/soc_uart_rx.sv | 252 +++++++++++++++++++++++++
 tb/tb_soc_uart_rx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_uart_pkg.sv
// soc_uart_pkg: shared definitions for the SoC UART receive path.
//   - rx_state_e        : receiver FSM states
//   - UART_RX_*         : register byte offsets on the peripheral bus
//   - STAT_*            : bit positions inside the STATUS register
//   - even_parity()     : parity bit that makes the total number of ones even
package soc_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic [7:0] UART_RX_DATA   = 8'h00;
  localparam logic [7:0] UART_RX_STATUS = 8'h04;
  localparam logic [7:0] UART_RX_CTRL   = 8'h08;

  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_OVERRUN   = 1;
  localparam int STAT_FRAMING   = 2;
  localparam int STAT_FULL      = 3;
  localparam int STAT_PARITY    = 4;
  localparam int STAT_COUNT_LSB = 8;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/soc_fifo.sv
// soc_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   push, wr_data : write request and data; ignored when full unless a pop
//                   is accepted in the same cycle
//   pop           : read request; ignored when empty
//   rd_data       : current head entry (valid while !empty)
//   full, empty   : occupancy flags
//   count         : number of stored entries, 0..DEPTH
module soc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [NW-1:0]    count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == NW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Head is read asynchronously so a bus read can return it in one cycle.
  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/soc_uart_rx.sv
// soc_uart_rx: UART receiver (8N1, or 8E1 when SOC_UART_RX_PARITY_EN is
// defined) with a receive FIFO, as a peripheral-bus responder.
//   clk, rst        : clock, synchronous active-high reset
//   rxd             : asynchronous serial input, idle high
//   ce/we/oe        : bus chip enable, write strobe, output enable
//   offset, data_in : register offset and write data
//   data_out, rdy   : read data (zero unless rdy) and access-complete pulse
//   irq             : level interrupt, CTRL.ie & (data or error pending)
// Registers: 0x00 DATA (read pops), 0x04 STATUS (W1C error bits), 0x08 CTRL.
module soc_uart_rx
  import soc_uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic        ce,
  input  logic        we,
  input  logic        oe,
  input  logic [7:0]  offset,
  input  logic [7:0]  data_in,
  output logic [31:0] data_out,
  output logic        rdy,
  output logic        irq
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int NW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);

  // ---------------- input synchroniser ----------------
  logic       rxd_meta_reg, rxd_sync_reg;
  logic [1:0] fill_reg;
  logic       armed_reg;

  // The sync stages reset high, so their first two outputs are not real
  // line samples; fill_reg marks when rxd_sync_reg holds genuine data.
  // armed_reg then requires a real high before any start bit is accepted,
  // so a line held low across reset is not mistaken for a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_reg <= 1'b1;
      rxd_sync_reg <= 1'b1;
      fill_reg     <= 2'b00;
      armed_reg    <= 1'b0;
    end else begin
      rxd_meta_reg <= rxd;
      rxd_sync_reg <= rxd_meta_reg;
      fill_reg     <= {fill_reg[0], 1'b1};
      if (fill_reg[1] && rxd_sync_reg) armed_reg <= 1'b1;
    end
  end

  // ---------------- receive FSM ----------------
  rx_state_e     state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          brk_reg, brk_next;        // waiting for line high after a bad stop bit
  logic          par_bad_reg, par_bad_next;
  logic          push_req, set_fe, set_pe;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      bit_reg     <= '0;
      shift_reg   <= '0;
      brk_reg     <= 1'b0;
      par_bad_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_reg     <= bit_next;
      shift_reg   <= shift_next;
      brk_reg     <= brk_next;
      par_bad_reg <= par_bad_next;
    end
  end

  // IDLE is only entered with the line high, so a low level there is a
  // falling edge.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_next     = bit_reg;
    shift_next   = shift_reg;
    brk_next     = brk_reg;
    par_bad_next = par_bad_reg;
    push_req     = 1'b0;
    set_fe       = 1'b0;
    set_pe       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (armed_reg && !rxd_sync_reg) begin
          state_next = ST_START;
          cnt_next   = '0;
        end
      end
      ST_START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next = '0;
          if (rxd_sync_reg) begin
            state_next = ST_IDLE;
          end else begin
            state_next   = ST_DATA;
            bit_next     = '0;
            par_bad_next = 1'b0;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          shift_next = {rxd_sync_reg, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) begin
`ifdef SOC_UART_RX_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
`ifdef SOC_UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          state_next = ST_STOP;
          if (rxd_sync_reg != even_parity(shift_reg)) begin
            set_pe       = 1'b1;
            par_bad_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (brk_reg) begin
          if (rxd_sync_reg) begin
            brk_next   = 1'b0;
            state_next = ST_IDLE;
          end
        end else if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (rxd_sync_reg) begin
            push_req   = ~par_bad_reg;
            state_next = ST_IDLE;
          end else begin
            set_fe   = 1'b1;
            brk_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- FIFO ----------------
  logic [7:0]    fifo_head;
  logic          fifo_full, fifo_empty;
  logic [NW-1:0] fifo_count;
  logic          pop_req;

  soc_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_req),
    .wr_data (shift_reg),
    .pop     (pop_req),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // ---------------- bus and registers ----------------
  logic        rdy_reg, irq_reg;
  logic [31:0] data_out_reg;
  logic        ovr_reg, fe_reg, pe_reg, ie_reg;
  logic        access, rd_access, wr_access, clr_status, set_ovr;
  logic [31:0] status_word, rd_value;
  logic        unused_data_in;

  // An access is taken in the cycle before rdy, so ce held high yields one
  // completion every second cycle.
  assign access     = ce & ~rdy_reg;
  assign rd_access  = access & oe;
  assign wr_access  = access & we;
  assign pop_req    = rd_access & (offset == UART_RX_DATA);
  assign clr_status = wr_access & (offset == UART_RX_STATUS);
  // A push into a full FIFO survives if the head is popped in the same cycle.
  assign set_ovr    = push_req & fifo_full & ~(pop_req & ~fifo_empty);
  assign unused_data_in = ^{data_in[7:5], data_in[3]};

  always_comb begin
    status_word = '0;
    status_word[STAT_NOT_EMPTY] = ~fifo_empty;
    status_word[STAT_OVERRUN]   = ovr_reg;
    status_word[STAT_FRAMING]   = fe_reg;
    status_word[STAT_FULL]      = fifo_full;
    status_word[STAT_PARITY]    = pe_reg;
    status_word[STAT_COUNT_LSB +: 8] = 8'(fifo_count);
  end

  always_comb begin
    rd_value = '0;
    case (offset)
      UART_RX_DATA:   rd_value = fifo_empty ? 32'h0 : {24'h0, fifo_head};
      UART_RX_STATUS: rd_value = status_word;
      UART_RX_CTRL:   rd_value = {31'h0, ie_reg};
      default:        rd_value = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_reg      <= 1'b0;
      data_out_reg <= '0;
      ovr_reg      <= 1'b0;
      fe_reg       <= 1'b0;
      pe_reg       <= 1'b0;
      ie_reg       <= 1'b0;
      irq_reg      <= 1'b0;
    end else begin
      rdy_reg      <= access;
      data_out_reg <= rd_access ? rd_value : 32'h0;
      // A new error event wins over a simultaneous write-1-to-clear.
      ovr_reg <= set_ovr | (ovr_reg & ~(clr_status & data_in[STAT_OVERRUN]));
      fe_reg  <= set_fe  | (fe_reg  & ~(clr_status & data_in[STAT_FRAMING]));
      pe_reg  <= set_pe  | (pe_reg  & ~(clr_status & data_in[STAT_PARITY]));
      if (wr_access && offset == UART_RX_CTRL) ie_reg <= data_in[0];
      irq_reg <= ie_reg & (~fifo_empty | ovr_reg | fe_reg | pe_reg);
    end
  end

  assign rdy      = rdy_reg;
  assign data_out = data_out_reg;
  assign irq      = irq_reg;

endmodule

// File: tb/tb_soc_uart_rx.sv
`timescale 1ns/1ps
module tb_soc_uart_rx;
  import soc_uart_pkg::*;

  localparam int CLK_DIV = 16;
  localparam int DEPTH   = 16;

  logic        clk = 1'b0;
  logic        rst, rxd, ce, we, oe;
  logic [7:0]  offset, data_in;
  logic [31:0] data_out;
  logic        rdy, irq;

  soc_uart_rx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .ce       (ce),
    .we       (we),
    .oe       (oe),
    .offset   (offset),
    .data_in  (data_in),
    .data_out (data_out),
    .rdy      (rdy),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: received bytes and the sticky register bits.
  byte unsigned model_q[$];
  bit m_ovr, m_fe, m_pe, m_ie;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All stimulus changes happen 1ns after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[0] = (model_q.size() > 0);
    s[1] = m_ovr;
    s[2] = m_fe;
    s[3] = (model_q.size() == DEPTH);
    s[4] = m_pe;
    s[15:8] = 8'(model_q.size());
    return s;
  endfunction

  function automatic logic exp_irq();
    return m_ie && (model_q.size() > 0 || m_ovr || m_fe || m_pe);
  endfunction

  task automatic model_reset();
    model_q.delete();
    m_ovr = 0; m_fe = 0; m_pe = 0; m_ie = 0;
  endtask

  // Outcome of one complete frame, straight from the receive rules.
  task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    bit par_good;
    par_good = 1'b1;
`ifdef SOC_UART_RX_PARITY_EN
    par_good = par_ok;
    if (!par_ok) m_pe = 1;
`endif
    if (!stop_ok) m_fe = 1;
    else if (par_good) begin
      if (model_q.size() == DEPTH) m_ovr = 1;
      else model_q.push_back(b);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    rxd = 1'b0;
    tick(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CLK_DIV);
    end
`ifdef SOC_UART_RX_PARITY_EN
    rxd = (^b) ^ ~par_ok;
    tick(CLK_DIV);
`endif
    rxd = stop_ok;
    tick(CLK_DIV);
    rxd = 1'b1;
    tick(4);
    model_frame(b, stop_ok, par_ok);
    $display("frame byte=%02h stop_ok=%0d par_ok=%0d", b, stop_ok, par_ok);
  endtask

  task automatic bus_access(input bit is_wr, input logic [7:0] off, input logic [7:0] wdata,
                            output logic [31:0] rdata);
    ce = 1'b1; we = is_wr; oe = ~is_wr; offset = off; data_in = wdata;
    tick(1);
    check_eq("rdy_latency", {31'h0, rdy}, 32'h1);
    rdata = data_out;
    ce = 1'b0; we = 1'b0; oe = 1'b0;
    tick(1);
    check_eq("rdy_pulse", {31'h0, rdy}, 32'h0);
    check_eq("dout_idle", data_out, 32'h0);
    $display("bus %s off=%02h wdata=%02h rdata=%08h", is_wr ? "wr" : "rd", off, wdata, rdata);
  endtask

  task automatic do_read(input logic [7:0] off, input string tag);
    logic [31:0] exp, got;
    exp = '0;
    if (off == UART_RX_DATA) begin
      if (model_q.size() > 0) exp = {24'h0, model_q.pop_front()};
    end else if (off == UART_RX_STATUS) exp = exp_status();
    else if (off == UART_RX_CTRL) exp = {31'h0, m_ie};
    bus_access(1'b0, off, 8'h00, got);
    check_eq(tag, got, exp);
  endtask

  task automatic do_write(input logic [7:0] off, input logic [7:0] v);
    logic [31:0] dummy;
    bus_access(1'b1, off, v, dummy);
    if (off == UART_RX_STATUS) begin
      if (v[1]) m_ovr = 0;
      if (v[2]) m_fe = 0;
`ifdef SOC_UART_RX_PARITY_EN
      if (v[4]) m_pe = 0;
`endif
    end else if (off == UART_RX_CTRL) m_ie = v[0];
  endtask

  task automatic check_irq(input string tag);
    check_eq(tag, {31'h0, irq}, {31'h0, exp_irq()});
  endtask

  initial begin
    int pulses;
    rst = 1'b1; rxd = 1'b1; ce = 1'b0; we = 1'b0; oe = 1'b0;
    offset = '0; data_in = '0;
    model_reset();
    tick(3);
    check_eq("reset_rdy", {31'h0, rdy}, 32'h0);
    check_eq("reset_irq", {31'h0, irq}, 32'h0);
    check_eq("reset_dout", data_out, 32'h0);
    rst = 1'b0;
    tick(4);
    do_read(UART_RX_STATUS, "reset_status");
    do_read(UART_RX_CTRL, "reset_ctrl");
    do_read(8'h0C, "unmapped_read");

    // Single frame.
    send_frame(8'h5A, 1'b1, 1'b1);
    do_read(UART_RX_STATUS, "status_one");
    do_read(UART_RX_DATA, "data_5a");
    do_read(UART_RX_STATUS, "status_after_pop");
    do_read(UART_RX_DATA, "data_empty");

    // Overflow: 17 frames into a 16-entry FIFO.
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, 1'b1);
    do_read(UART_RX_STATUS, "status_full_ovr");
    for (int i = 0; i < 16; i++) do_read(UART_RX_DATA, "drain");
    do_write(UART_RX_STATUS, 8'h02);
    do_read(UART_RX_STATUS, "ovr_cleared");

    // Framing error.
    send_frame(8'hA5, 1'b0, 1'b1);
    do_read(UART_RX_STATUS, "status_framing");
    do_write(UART_RX_STATUS, 8'h04);
    do_read(UART_RX_STATUS, "framing_cleared");

    // Short low pulse must be rejected.
    rxd = 1'b0; tick(4); rxd = 1'b1; tick(30);
    do_read(UART_RX_STATUS, "glitch_status");
    send_frame(8'h33, 1'b1, 1'b1);
    do_read(UART_RX_DATA, "data_33");

    // Interrupt.
    do_write(UART_RX_CTRL, 8'h01);
    check_irq("irq_ie_only");
    send_frame(8'h11, 1'b1, 1'b1);
    check_irq("irq_data");
    do_read(UART_RX_DATA, "data_11");
    check_irq("irq_after_pop");

    // Back-to-back accesses with ce held high.
    ce = 1'b1; oe = 1'b1; we = 1'b0; offset = UART_RX_STATUS;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (rdy) pulses++;
    end
    ce = 1'b0; oe = 1'b0;
    tick(1);
    check_eq("b2b_pulses", pulses, 3);

    // Reset in the middle of a frame, line low across reset.
    send_frame(8'h22, 1'b1, 1'b1);
    check_irq("irq_before_rst");
    rxd = 1'b0; tick(CLK_DIV);
    rxd = 1'b1; tick(CLK_DIV);     // bit0 of 0xA5
    rxd = 1'b0; tick(CLK_DIV);     // bit1
    rxd = 1'b1; tick(CLK_DIV);     // bit2
    rxd = 1'b0; tick(CLK_DIV / 2); // half of bit3
    rst = 1'b1; tick(1); rst = 1'b0;
    model_reset();
    check_eq("rst_irq", {31'h0, irq}, 32'h0);
    check_eq("rst_dout", data_out, 32'h0);
    tick(20);
    rxd = 1'b1; tick(20);
    do_read(UART_RX_STATUS, "rst_status");
    do_read(UART_RX_CTRL, "rst_ctrl");
    send_frame(8'h7E, 1'b1, 1'b1);
    do_read(UART_RX_DATA, "data_7e");
    do_read(UART_RX_STATUS, "status_after_7e");

`ifdef SOC_UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    do_read(UART_RX_STATUS, "parity_bad");
    do_write(UART_RX_STATUS, 8'h10);
    do_read(UART_RX_STATUS, "parity_cleared");
    send_frame(8'h07, 1'b1, 1'b1);
    do_read(UART_RX_DATA, "parity_good_07");
`endif

    // Randomised traffic against the model.
    for (int it = 0; it < 60; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 3) send_frame(8'($urandom), $urandom_range(0, 9) != 0, $urandom_range(0, 7) != 0);
      else if (r <= 5) do_read(UART_RX_DATA, "rnd_data");
      else if (r == 6) do_read(UART_RX_STATUS, "rnd_status");
      else if (r == 7) do_write(UART_RX_STATUS, 8'($urandom));
      else if (r == 8) do_write(UART_RX_CTRL, 8'($urandom));
      else do_read(UART_RX_CTRL, "rnd_ctrl");
      check_irq("rnd_irq");
    end
    do_read(UART_RX_STATUS, "final_status");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
